data_cache_fill_unit: RTL and testbench
=======================================

DATA_CACHE_FILL_UNIT -- requirements
Module: data_cache_fill_unit

Interface
REQ-001 Parameters SHALL be none; sizes SHALL come from data_memory_pkg: CACHE_CHIP (banks per line), CHIP_ADDR (bank index width), PORT_WIDTH (32).
REQ-002 clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 fill_request_i  in  1  start a line fill; sampled only in IDLE.
REQ-005 fill_address_i  in  data_cache_address_t  line index to fill.
REQ-006 fill_bank_i  in  CHIP_ADDR  bank holding the word the core missed on (critical word).
REQ-007 fill_busy_o  out  1  high while not IDLE.
REQ-008 fill_done_o  out  1  one-cycle pulse at fill completion.
REQ-009 mem_data_i  in  PORT_WIDTH  refill word from memory.
REQ-010 mem_valid_i  in  1  mem_data_i valid.
REQ-011 mem_ready_o  out  1  unit accepts a beat; a beat SHALL transfer when mem_valid_i & mem_ready_o.
REQ-012 cache_write_o  out  1  drives data_cache_block port0_write_i.
REQ-013 cache_address_o  out  data_cache_address_t  drives port0_address_i.
REQ-014 cache_bank_select_o  out  CHIP_ADDR  drives port0_bank_select_i.
REQ-015 cache_byte_write_o  out  data_cache_byte_write_t  drives port0_byte_write_i.
REQ-016 cache_data_o  out  PORT_WIDTH  drives port0_data_i.
REQ-017 critical_word_valid_o  out  1  one-cycle pulse; critical_word_o valid.
REQ-018 critical_word_o  out  PORT_WIDTH  forwarded critical word.

Function
REQ-019 FSM SHALL have states IDLE, FILL, DONE.
REQ-020 IDLE -> FILL when fill_request_i=1; fill_address_i and fill_bank_i SHALL be latched that edge; beat counter cleared to 0.
REQ-021 fill_request_i in FILL or DONE SHALL be ignored (no queueing).
REQ-022 mem_ready_o SHALL be 1 exactly in FILL; beats with mem_valid_i=0 SHALL not advance any state.
REQ-023 Each accepted beat SHALL produce, on the next cycle only, cache_write_o=1 with cache_data_o=beat, cache_address_o=latched index, cache_bank_select_o=current bank, cache_byte_write_o all ones; otherwise cache_write_o=0.
REQ-024 Current bank SHALL advance by 1 modulo CACHE_CHIP per accepted beat (wrap from CACHE_CHIP-1 to 0).
REQ-025 FILL -> DONE on acceptance of beat CACHE_CHIP-1 (counter counts 0..CACHE_CHIP-1); DONE -> IDLE unconditionally after one cycle.
REQ-026 fill_done_o SHALL be 1 exactly in DONE, coincident with the last cache write.
REQ-027 When the written bank equals latched fill_bank_i, critical_word_valid_o SHALL pulse with critical_word_o=that word, same cycle as its cache write; exactly once per fill.
REQ-028 Fill latency SHALL be CACHE_CHIP accepted beats + 1 cycle; back-to-back beats SHALL sustain one write per cycle.
REQ-029 fill_busy_o SHALL be 1 in FILL and DONE.

Reset
REQ-030 rst_n_i=0 SHALL force IDLE immediately, regardless of clock, aborting any fill mid-line; no further cache writes for that fill.
REQ-031 Reset values: fill_busy_o, fill_done_o, mem_ready_o, cache_write_o, critical_word_valid_o = 0; cache_address_o, cache_bank_select_o, cache_data_o, critical_word_o = 0; cache_byte_write_o = all ones; counter and latched bank = 0.

Configuration
REQ-032 Macro FILL_CRITICAL_WORD_FIRST_EN defined: first bank written = latched fill_bank_i, then wraps per REQ-024; critical_word_valid_o on first write.
REQ-033 Macro undefined: first bank written = 0, ascending; critical_word_valid_o on write of bank fill_bank_i.

Verification (CACHE_CHIP=4)
REQ-034 Request index 0x12, bank 2, beats A,B,C,D back-to-back -> writes banks 0,1,2,3 (macro off) / 2,3,0,1 (macro on) to index 0x12, bytes all ones; fill_done_o with 4th write.
REQ-035 Same fill, macro off -> critical pulse with C; macro on -> critical pulse with A on first write.
REQ-036 mem_valid_i gaps (valid 1,0,0,1,1,0,1) -> exactly 4 writes, none in gap-following cycles, done after 4th.
REQ-037 fill_request_i held high through fill with new index 0x3F -> ignored; next fill starts only after DONE->IDLE and uses index sampled in IDLE.
REQ-038 rst_n_i low after 2 beats, asynchronously mid-cycle -> all outputs to reset values immediately; no 3rd write; fresh request afterwards fills all 4 banks from the start.

Source files
------------

// File: rtl/data_cache_fill_unit.sv
// ============================================================================
// Module      : data_cache_fill_unit
// Description : Refills one data-cache line from a valid/ready memory stream,
//               one bank write per accepted beat, forwarding the critical word.
//               Define FILL_CRITICAL_WORD_FIRST_EN to start the fill at the
//               missed bank instead of bank 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_memory_pkg;
    parameter int CACHE_CHIP = 4;
    parameter int CHIP_ADDR  = 2;
    parameter int PORT_WIDTH = 32;
    typedef logic [7:0]            data_cache_address_t;
    typedef logic [PORT_WIDTH/8-1:0] data_cache_byte_write_t;
endpackage

module data_cache_fill_unit
    import data_memory_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   fill_request_i,
    input  data_cache_address_t    fill_address_i,
    input  logic [CHIP_ADDR-1:0]   fill_bank_i,
    output logic                   fill_busy_o,
    output logic                   fill_done_o,
    input  logic [PORT_WIDTH-1:0]  mem_data_i,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    output logic                   cache_write_o,
    output data_cache_address_t    cache_address_o,
    output logic [CHIP_ADDR-1:0]   cache_bank_select_o,
    output data_cache_byte_write_t cache_byte_write_o,
    output logic [PORT_WIDTH-1:0]  cache_data_o,
    output logic                   critical_word_valid_o,
    output logic [PORT_WIDTH-1:0]  critical_word_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    localparam logic [CHIP_ADDR-1:0] c_last_bank = CHIP_ADDR'(CACHE_CHIP - 1);

    fill_state_t            r_state;
    data_cache_address_t    r_address;
    logic [CHIP_ADDR-1:0]   r_crit_bank;
    logic [CHIP_ADDR-1:0]   r_bank;
    logic [CHIP_ADDR-1:0]   r_count;
    logic [CHIP_ADDR-1:0]   w_next_bank;
    logic [CHIP_ADDR-1:0]   w_start_bank;

    assign w_next_bank = (r_bank == c_last_bank) ? '0 : r_bank + 1'b1;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    assign w_start_bank = fill_bank_i;
`else
    assign w_start_bank = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state               <= ST_IDLE;
            r_address             <= '0;
            r_crit_bank           <= '0;
            r_bank                <= '0;
            r_count               <= '0;
            fill_busy_o           <= 1'b0;
            fill_done_o           <= 1'b0;
            mem_ready_o           <= 1'b0;
            cache_write_o         <= 1'b0;
            cache_address_o       <= '0;
            cache_bank_select_o   <= '0;
            cache_byte_write_o    <= '1;
            cache_data_o          <= '0;
            critical_word_valid_o <= 1'b0;
            critical_word_o       <= '0;
        end else begin
            // Pulses default low; write-side data registers hold their last value.
            cache_write_o         <= 1'b0;
            fill_done_o           <= 1'b0;
            critical_word_valid_o <= 1'b0;
            cache_byte_write_o    <= '1;
            case (r_state)
                ST_IDLE: begin
                    if (fill_request_i) begin
                        r_state     <= ST_FILL;
                        r_address   <= fill_address_i;
                        r_crit_bank <= fill_bank_i;
                        r_bank      <= w_start_bank;
                        r_count     <= '0;
                        fill_busy_o <= 1'b1;
                        mem_ready_o <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (mem_valid_i) begin
                        cache_write_o       <= 1'b1;
                        cache_data_o        <= mem_data_i;
                        cache_address_o     <= r_address;
                        cache_bank_select_o <= r_bank;
                        if (r_bank == r_crit_bank) begin
                            critical_word_valid_o <= 1'b1;
                            critical_word_o       <= mem_data_i;
                        end
                        r_bank  <= w_next_bank;
                        r_count <= r_count + 1'b1;
                        if (r_count == c_last_bank) begin
                            r_state     <= ST_DONE;
                            mem_ready_o <= 1'b0;
                            fill_done_o <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    fill_busy_o <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    fill_busy_o <= 1'b0;
                    mem_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_cache_fill_unit.sv
// ============================================================================
// Module      : tb_data_cache_fill_unit
// Description : Randomized self-checking bench for data_cache_fill_unit,
//               compared against a per-fill transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_cache_fill_unit;
    import data_memory_pkg::*;

    logic                   clk_i;
    logic                   rst_n_i;
    logic                   fill_request_i;
    data_cache_address_t    fill_address_i;
    logic [CHIP_ADDR-1:0]   fill_bank_i;
    logic                   fill_busy_o;
    logic                   fill_done_o;
    logic [PORT_WIDTH-1:0]  mem_data_i;
    logic                   mem_valid_i;
    logic                   mem_ready_o;
    logic                   cache_write_o;
    data_cache_address_t    cache_address_o;
    logic [CHIP_ADDR-1:0]   cache_bank_select_o;
    data_cache_byte_write_t cache_byte_write_o;
    logic [PORT_WIDTH-1:0]  cache_data_o;
    logic                   critical_word_valid_o;
    logic [PORT_WIDTH-1:0]  critical_word_o;

    int n_checks;
    int n_bad;

    data_cache_fill_unit u_dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .fill_request_i        (fill_request_i),
        .fill_address_i        (fill_address_i),
        .fill_bank_i           (fill_bank_i),
        .fill_busy_o           (fill_busy_o),
        .fill_done_o           (fill_done_o),
        .mem_data_i            (mem_data_i),
        .mem_valid_i           (mem_valid_i),
        .mem_ready_o           (mem_ready_o),
        .cache_write_o         (cache_write_o),
        .cache_address_o       (cache_address_o),
        .cache_bank_select_o   (cache_bank_select_o),
        .cache_byte_write_o    (cache_byte_write_o),
        .cache_data_o          (cache_data_o),
        .critical_word_valid_o (critical_word_valid_o),
        .critical_word_o       (critical_word_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, ".busy"},  32'(fill_busy_o), 32'd0);
        check_value({tag, ".done"},  32'(fill_done_o), 32'd0);
        check_value({tag, ".ready"}, 32'(mem_ready_o), 32'd0);
        check_value({tag, ".wr"},    32'(cache_write_o), 32'd0);
        check_value({tag, ".crv"},   32'(critical_word_valid_o), 32'd0);
        check_value({tag, ".addr"},  32'(cache_address_o), 32'd0);
        check_value({tag, ".bank"},  32'(cache_bank_select_o), 32'd0);
        check_value({tag, ".data"},  cache_data_o, 32'd0);
        check_value({tag, ".crw"},   critical_word_o, 32'd0);
        check_value({tag, ".bytes"}, 32'(cache_byte_write_o), 32'(data_cache_byte_write_t'('1)));
    endtask

    // First bank written for a fill whose missed bank is cbank.
    function automatic int start_bank(input int cbank);
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        return cbank;
`else
        return 0;
`endif
    endfunction

    // max_gap < 0 selects the fixed valid pattern 1,0,0,1,1,0,1.
    task automatic run_fill(input data_cache_address_t addr, input int cbank,
                            input int max_gap, input bit hold_req);
        logic [31:0] words [CACHE_CHIP];
        int          gaps;
        int          bank;
        int          crit_seen;
        crit_seen = 0;
        for (int i = 0; i < CACHE_CHIP; i++) words[i] = $urandom;

        fill_request_i = 1'b1;
        fill_address_i = addr;
        fill_bank_i    = CHIP_ADDR'(cbank);
        mem_valid_i    = 1'($urandom_range(0, 1));
        mem_data_i     = $urandom;
        step();
        check_value("req.busy",  32'(fill_busy_o), 32'd1);
        check_value("req.ready", 32'(mem_ready_o), 32'd1);
        check_value("req.wr",    32'(cache_write_o), 32'd0);

        if (hold_req) begin
            fill_address_i = 8'h3F;
            fill_bank_i    = CHIP_ADDR'(cbank + 1);
        end else begin
            fill_request_i = 1'b0;
            fill_address_i = data_cache_address_t'($urandom);
            fill_bank_i    = CHIP_ADDR'($urandom);
        end

        for (int i = 0; i < CACHE_CHIP; i++) begin
            if (max_gap < 0) gaps = (i == 1) ? 2 : ((i == 3) ? 1 : 0);
            else             gaps = $urandom_range(0, max_gap);
            for (int g = 0; g < gaps; g++) begin
                mem_valid_i = 1'b0;
                mem_data_i  = $urandom;
                step();
                check_value("gap.wr",    32'(cache_write_o), 32'd0);
                check_value("gap.ready", 32'(mem_ready_o), 32'd1);
                check_value("gap.done",  32'(fill_done_o), 32'd0);
            end
            mem_valid_i = 1'b1;
            mem_data_i  = words[i];
            step();
            bank = (start_bank(cbank) + i) % CACHE_CHIP;
            check_value("beat.wr",    32'(cache_write_o), 32'd1);
            check_value("beat.data",  cache_data_o, words[i]);
            check_value("beat.addr",  32'(cache_address_o), 32'(addr));
            check_value("beat.bank",  32'(cache_bank_select_o), 32'(bank));
            check_value("beat.bytes", 32'(cache_byte_write_o), 32'(data_cache_byte_write_t'('1)));
            check_value("beat.busy",  32'(fill_busy_o), 32'd1);
            check_value("beat.done",  32'(fill_done_o), (i == CACHE_CHIP - 1) ? 32'd1 : 32'd0);
            check_value("beat.ready", 32'(mem_ready_o), (i == CACHE_CHIP - 1) ? 32'd0 : 32'd1);
            check_value("beat.crv",   32'(critical_word_valid_o), (bank == cbank) ? 32'd1 : 32'd0);
            if (critical_word_valid_o) begin
                crit_seen++;
                check_value("beat.crw", critical_word_o, words[i]);
            end
        end
        mem_valid_i = 1'($urandom_range(0, 1));
        mem_data_i  = $urandom;
        step();
        check_value("end.busy",  32'(fill_busy_o), 32'd0);
        check_value("end.done",  32'(fill_done_o), 32'd0);
        check_value("end.wr",    32'(cache_write_o), 32'd0);
        check_value("end.ready", 32'(mem_ready_o), 32'd0);
        check_value("end.crit_count", 32'(crit_seen), 32'd1);
        mem_valid_i = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_bad          = 0;
        rst_n_i        = 1'b0;
        fill_request_i = 1'b0;
        fill_address_i = '0;
        fill_bank_i    = '0;
        mem_data_i     = '0;
        mem_valid_i    = 1'b0;
        step();
        step();
        check_reset_outputs("rst");
        rst_n_i = 1'b1;
        step();
        check_reset_outputs("idle");

        // Directed: index 0x12, critical bank 2, back-to-back beats.
        run_fill(8'h12, 2, 0, 1'b0);
        // Directed: valid pattern with gaps.
        run_fill(8'h12, 2, -1, 1'b0);
        // Request held high with a new index during the fill.
        run_fill(8'h21, 1, 1, 1'b1);
        run_fill(8'h3F, 3, 0, 1'b0);

        // Asynchronous reset after two beats, mid-cycle.
        fill_request_i = 1'b1;
        fill_address_i = 8'h55;
        fill_bank_i    = 2'd3;
        step();
        fill_request_i = 1'b0;
        mem_valid_i    = 1'b1;
        mem_data_i     = 32'hAAAA_0001;
        step();
        mem_data_i     = 32'hAAAA_0002;
        step();
        check_value("pre_rst.wr", 32'(cache_write_o), 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        mem_data_i = 32'hAAAA_0003;
        step();
        check_value("in_rst.wr", 32'(cache_write_o), 32'd0);
        rst_n_i = 1'b1;
        step();
        check_value("post_rst.wr",   32'(cache_write_o), 32'd0);
        check_value("post_rst.busy", 32'(fill_busy_o), 32'd0);
        mem_valid_i = 1'b0;
        run_fill(8'h66, 0, 0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_fill(data_cache_address_t'($urandom), $urandom_range(0, CACHE_CHIP - 1),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        fill_request_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
